// File: rtl/pkt_replay_pkg.sv
`default_nettype none
// ============================================================================
// Package  : pkt_replay_pkg
// Desc     : Shared state encoding and default widths for the packet replay
//            source and its RAM.
// Revision : 1.0 - initial release
// ============================================================================
package pkt_replay_pkg;

    // Default widths: data, RAM address, gap length, repeat/packet counters
    localparam int c_DEF_DW = 8;
    localparam int c_DEF_AW = 10;
    localparam int c_DEF_GW = 8;
    localparam int c_DEF_CW = 16;

    typedef logic [1:0] state_t;

    localparam state_t c_ST_IDLE  = 2'd0;
    localparam state_t c_ST_PRIME = 2'd1;
    localparam state_t c_ST_SEND  = 2'd2;
    localparam state_t c_ST_GAP   = 2'd3;

endpackage : pkt_replay_pkg
`default_nettype wire

// File: rtl/dpram_sync.sv
`default_nettype none
// ============================================================================
// Module   : dpram_sync
// Desc     : Simple dual-port RAM, one write port and one synchronous read
//            port. Read data only changes when i_re is high, so the read
//            register doubles as a holding register for a stalled consumer.
// Revision : 1.0 - initial release
// ============================================================================
module dpram_sync
    import pkt_replay_pkg::*;
#(
    parameter int DW = c_DEF_DW,
    parameter int AW = c_DEF_AW
)(
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [0:(1<<AW)-1];

    // Write port
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read port; holds its value when not enabled
    always_ff @(posedge clk) begin
        if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule : dpram_sync
`default_nettype wire

// File: rtl/pkt_replay_src.sv
`default_nettype none
// ============================================================================
// Module   : pkt_replay_src
// Desc     : Replays the first data_len bytes of an internal RAM as framed
//            valid/ready packets with a programmable inter-packet gap and
//            repeat count.
// Revision : 1.0 - initial release
// ============================================================================
module pkt_replay_src
    import pkt_replay_pkg::*;
#(
    parameter int DW = c_DEF_DW,
    parameter int AW = c_DEF_AW,
    parameter int GW = c_DEF_GW,
    parameter int CW = c_DEF_CW
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          start,
    input  logic          stop,
    input  logic [AW:0]   data_len,
    input  logic [GW-1:0] gap_len,
    input  logic [CW-1:0] repeat_cnt,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    output logic          out_last,
    input  logic          out_ready,
    output logic          busy,
    output logic [CW-1:0] pkt_count,
    output logic          cfg_err
);

    localparam logic [AW:0] c_DEPTH = {1'b1, {AW{1'b0}}};

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW:0]   r_len;
    logic [AW:0]   r_idx;
    logic [GW-1:0] r_gap;
    logic [GW-1:0] r_gap_cnt;
    logic [CW-1:0] r_rep;
    logic [CW-1:0] r_pkt_count;
    logic          r_stop_pend;
    logic          r_cfg_err;

    logic          w_ram_we;
    logic          w_ram_re;
    logic [AW-1:0] w_ram_raddr;
    logic [DW-1:0] w_ram_rdata;

    logic          w_idle;
    logic          w_start_ok;
    logic          w_start_bad;
    logic          w_wr_bad;
    logic          w_accept;
    logic          w_last_byte;
    logic          w_pkt_done;
    logic          w_stop_now;
    logic          w_finish;
    logic          w_gap_end;
    logic [AW:0]   w_idx_inc;
    logic [CW-1:0] w_cnt_inc;

    assign w_idle      = (r_state == c_ST_IDLE);
    assign w_start_ok  = w_idle && start && (data_len != '0);
    assign w_start_bad = w_idle && start && (data_len == '0);
    // Writes only land while idle so a running replay never sees torn data
    assign w_ram_we    = wr_en && w_idle;
    assign w_wr_bad    = wr_en && !w_idle;
    assign w_accept    = (r_state == c_ST_SEND) && out_ready;
    assign w_last_byte = (r_idx == (r_len - (AW+1)'(1)));
    assign w_pkt_done  = w_accept && w_last_byte;
    assign w_idx_inc   = r_idx + (AW+1)'(1);
    assign w_cnt_inc   = r_pkt_count + CW'(1);
    // A stop arriving together with the final accept still ends the run
    assign w_stop_now  = r_stop_pend || stop;
    assign w_finish    = w_pkt_done &&
                         (w_stop_now || ((r_rep != '0) && (w_cnt_inc == r_rep)));
    assign w_gap_end   = (r_gap_cnt == (r_gap - GW'(1)));

    dpram_sync #(
        .DW (DW),
        .AW (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_waddr (wr_addr),
        .i_wdata (wr_data),
        .i_re    (w_ram_re),
        .i_raddr (w_ram_raddr),
        .o_rdata (w_ram_rdata)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_start_ok) w_state_nxt = c_ST_PRIME;
            end
            c_ST_PRIME: begin
                w_state_nxt = c_ST_SEND;
            end
            c_ST_SEND: begin
                if (w_pkt_done) begin
                    if (w_finish)           w_state_nxt = c_ST_IDLE;
                    else if (r_gap == '0)   w_state_nxt = c_ST_SEND;
                    else                    w_state_nxt = c_ST_GAP;
                end
            end
            c_ST_GAP: begin
                if (w_stop_now)     w_state_nxt = c_ST_IDLE;
                else if (w_gap_end) w_state_nxt = c_ST_SEND;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Stream outputs and RAM read control; reads are issued one cycle ahead
    always_comb begin
        w_ram_re    = 1'b0;
        w_ram_raddr = '0;
        case (r_state)
            c_ST_PRIME: begin
                w_ram_re = 1'b1;
            end
            c_ST_SEND: begin
                if (w_accept) begin
                    w_ram_re    = 1'b1;
                    w_ram_raddr = w_last_byte ? '0 : w_idx_inc[AW-1:0];
                end
            end
            c_ST_GAP: begin
                w_ram_re = w_gap_end;
            end
            default: begin
                w_ram_re = 1'b0;
            end
        endcase
        out_valid = (r_state == c_ST_SEND);
        out_last  = out_valid && w_last_byte;
        // Masked so the bus reads zero outside SEND, including during reset
        out_data  = out_valid ? w_ram_rdata : '0;
        busy      = !w_idle;
        pkt_count = r_pkt_count;
        cfg_err   = r_cfg_err;
    end

    // Configuration capture, byte index, gap timer, packet counter, stop latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len       <= '0;
            r_idx       <= '0;
            r_gap       <= '0;
            r_gap_cnt   <= '0;
            r_rep       <= '0;
            r_pkt_count <= '0;
            r_stop_pend <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_cfg_err <= w_start_bad || w_wr_bad;
            if (w_start_ok) begin
                r_len       <= (data_len > c_DEPTH) ? c_DEPTH : data_len;
                r_gap       <= gap_len;
                r_rep       <= repeat_cnt;
                r_pkt_count <= '0;
                r_idx       <= '0;
            end
            if (w_accept) begin
                r_idx <= w_last_byte ? '0 : w_idx_inc;
            end
            if (w_pkt_done) begin
                r_pkt_count <= w_cnt_inc;
            end
            if (r_state == c_ST_GAP) begin
                r_gap_cnt <= r_gap_cnt + GW'(1);
            end else begin
                r_gap_cnt <= '0;
            end
            if (w_idle) begin
                r_stop_pend <= 1'b0;
            end else if (stop) begin
                r_stop_pend <= 1'b1;
            end
        end
    end

endmodule : pkt_replay_src
`default_nettype wire
